// File: rtl/regfile_read_bypass.sv
// ---------------------------------------------------------------------------
// regfile_read_bypass
//
// Sits behind the 4-write / 8-read CGRA register file. The file registers its
// read outputs before the same cycle's writes land, so a read and a write to
// the same address in one cycle return the old value. This block snoops the
// same write ports and read addresses, substitutes the write data when an
// address matches, and registers the corrected data for each read port.
//
// Pipeline:
//   cycle t   : request (rd_en / address_out), writes (WE / address_in / in)
//               are captured into the s1 registers. The register file samples
//               its array into rf_out on the same edge.
//   cycle t+1 : each port selects either the youngest matching write data or
//               rf_out. The result is registered into out / out_valid.
//   Read latency is 2 cycles from rd_en to out_valid, with 1 request per port
//   per cycle.
//
// Handshake: out_valid[k] is a one-cycle strobe with no ready or backpressure.
// The consumer must take out slice k on the cycle that out_valid[k] is high.
// When out_valid[k] is low, out slice k holds the last delivered value.
//
// Ports:
//   CGRA_Clock    in   1              rising-edge clock
//   CGRA_Reset    in   1              synchronous, active-low reset
//   WE            in   4              write enables (mirrors WE0..WE3)
//   address_in    in   4*log2regs     write addresses, slice j = port j
//   in            in   4*size         write data, slice j = port j
//   rd_en         in   8              read request valid per port
//   address_out   in   8*log2regs     read addresses, slice k = port k
//   rf_out        in   8*size         register-file outputs out0..out7
//   out           out  8*size         corrected read data per port
//   out_valid     out  8              slice k carries a new result
//   bypass_count  out  CNT_W          saturating count of bypassed reads
//   clear_count   in   1              synchronous clear of bypass_count
// ---------------------------------------------------------------------------
module regfile_read_bypass #(
  parameter int log2regs = 3,
  parameter int size     = 32,
  parameter int CNT_W    = 16
) (
  input  logic                    CGRA_Clock,
  input  logic                    CGRA_Reset,
  input  logic [3:0]              WE,
  input  logic [4*log2regs-1:0]   address_in,
  input  logic [4*size-1:0]       in,
  input  logic [7:0]              rd_en,
  input  logic [8*log2regs-1:0]   address_out,
  input  logic [8*size-1:0]       rf_out,
  output logic [8*size-1:0]       out,
  output logic [7:0]              out_valid,
  output logic [CNT_W-1:0]        bypass_count,
  input  logic                    clear_count
);

  // The sum is wide enough to hold the counter plus up to 8 increments
  // without overflow, so saturation can be decided after the add.
  localparam int SUM_W = ((CNT_W > 4) ? CNT_W : 4) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  // Stage S1 registers
  logic [7:0]              s1_rd_en;
  logic [8*log2regs-1:0]   s1_address_out;
  logic [3:0]              s1_we;
  logic [4*log2regs-1:0]   s1_address_in;
  logic [4*size-1:0]       s1_in;

  // Stage S2 combinational results
  logic [8*size-1:0]       sel_data;
  logic [7:0]              hit_any;
  logic [3:0]              hit_cnt;
  logic [SUM_W-1:0]        cnt_sum;
  logic [CNT_W-1:0]        cnt_next;

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      s1_rd_en       <= '0;
      s1_address_out <= '0;
      s1_we          <= '0;
      s1_address_in  <= '0;
      s1_in          <= '0;
    end else begin
      s1_rd_en       <= rd_en;
      s1_address_out <= address_out;
      s1_we          <= WE;
      s1_address_in  <= address_in;
      s1_in          <= in;
    end
  end

  // Write ports are scanned in ascending order, so the highest-numbered
  // matching port overrides the lower ones. This matches the file's
  // last-write-wins order.
  always_comb begin
    sel_data = rf_out;
    hit_any  = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (s1_we[j] &&
            (s1_address_in[j*log2regs +: log2regs] ==
             s1_address_out[k*log2regs +: log2regs])) begin
          sel_data[k*size +: size] = s1_in[j*size +: size];
          hit_any[k]               = 1'b1;
        end
      end
    end
  end

  // A bypass is counted only for an enabled read.
  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      hit_cnt = hit_cnt + {3'b000, (s1_rd_en[k] & hit_any[k])};
    end
    cnt_sum = SUM_W'(bypass_count) + SUM_W'(hit_cnt);
    if (cnt_sum > CNT_MAX) begin
      cnt_next = {CNT_W{1'b1}};
    end else begin
      cnt_next = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      out          <= '0;
      out_valid    <= '0;
      bypass_count <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (s1_rd_en[k]) begin
          out[k*size +: size] <= sel_data[k*size +: size];
        end
      end
      out_valid <= s1_rd_en;
      if (clear_count) begin
        bypass_count <= '0;
      end else begin
        bypass_count <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_bypass.sv
// ---------------------------------------------------------------------------
// Bench for regfile_read_bypass. A small behavioural register file supplies
// rf_out: it registers reads before that cycle's writes land. The expected
// values below are worked out by hand from the stimulus. The counter is built
// 4 bits wide so that saturation is reachable.
// ---------------------------------------------------------------------------
module tb_regfile_read_bypass;

  localparam int L  = 3;
  localparam int SZ = 32;
  localparam int CW = 4;

  logic              clk;
  logic              rst_n;
  logic [3:0]        we;
  logic [4*L-1:0]    address_in;
  logic [4*SZ-1:0]   wdata;
  logic [7:0]        rd_en;
  logic [8*L-1:0]    address_out;
  logic [8*SZ-1:0]   rf_out;
  logic [8*SZ-1:0]   out;
  logic [7:0]        out_valid;
  logic [CW-1:0]     bypass_count;
  logic              clear_count;

  int total;
  int bad;

  logic [SZ-1:0] mem [8];

  regfile_read_bypass #(.log2regs(L), .size(SZ), .CNT_W(CW)) dut (
    .CGRA_Clock   (clk),
    .CGRA_Reset   (rst_n),
    .WE           (we),
    .address_in   (address_in),
    .in           (wdata),
    .rd_en        (rd_en),
    .address_out  (address_out),
    .rf_out       (rf_out),
    .out          (out),
    .out_valid    (out_valid),
    .bypass_count (bypass_count),
    .clear_count  (clear_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: reads see the array before this edge's writes.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rf_out = '0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) rf_out[k*SZ +: SZ] <= mem[address_out[k*L +: L]];
    for (int j = 0; j < 4; j++) if (we[j]) mem[address_in[j*L +: L]] <= wdata[j*SZ +: SZ];
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    address_in  = '0;
    wdata       = '0;
    rd_en       = '0;
    address_out = '0;
    clear_count = 1'b0;
  endtask

  task automatic drive_write(input int j, input logic [L-1:0] a, input logic [SZ-1:0] d);
    we[j]                = 1'b1;
    address_in[j*L +: L] = a;
    wdata[j*SZ +: SZ]    = d;
  endtask

  task automatic drive_read(input int k, input logic [L-1:0] a);
    rd_en[k]              = 1'b1;
    address_out[k*L +: L] = a;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
    total++;
    if (bypass_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bypass_count); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_plain_read();
    idle();
    drive_write(0, 3'd2, 32'h0000_00AA);
    step();
    idle();
    drive_read(0, 3'd2);
    step();
    idle();
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL plain_latency valid got=%h exp=00", out_valid); end
    step();
    total++;
    if (out[0*SZ +: SZ] !== 32'h0000_00AA) begin bad++; $display("FAIL plain_data got=%h exp=000000aa", out[0*SZ +: SZ]); end
    total++;
    if (out_valid !== 8'h01) begin bad++; $display("FAIL plain_valid got=%h exp=01", out_valid); end
    total++;
    if (bypass_count !== 4'd0) begin bad++; $display("FAIL plain_count got=%0d exp=0", bypass_count); end
    step();
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL plain_strobe valid got=%h exp=00", out_valid); end
  endtask

  task automatic test_hazard();
    idle();
    drive_write(1, 3'd5, 32'hDEAD_BEEF);
    drive_read(4, 3'd5);
    step();
    idle();
    step();
    total++;
    if (out[4*SZ +: SZ] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hazard_data got=%h exp=deadbeef", out[4*SZ +: SZ]); end
    total++;
    if (out_valid !== 8'h10) begin bad++; $display("FAIL hazard_valid got=%h exp=10", out_valid); end
    total++;
    if (bypass_count !== 4'd1) begin bad++; $display("FAIL hazard_count got=%0d exp=1", bypass_count); end
    total++;
    if (out[0*SZ +: SZ] !== 32'h0000_00AA) begin bad++; $display("FAIL hazard_hold0 got=%h exp=000000aa", out[0*SZ +: SZ]); end
  endtask

  task automatic test_priority();
    idle();
    drive_write(0, 3'd7, 32'h0000_0011);
    drive_write(3, 3'd7, 32'h0000_0033);
    for (int k = 0; k < 8; k++) drive_read(k, 3'd7);
    step();
    idle();
    step();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out[k*SZ +: SZ] !== 32'h0000_0033) begin
        bad++; $display("FAIL prio_data%0d got=%h exp=00000033", k, out[k*SZ +: SZ]);
      end
    end
    total++;
    if (out_valid !== 8'hFF) begin bad++; $display("FAIL prio_valid got=%h exp=ff", out_valid); end
    total++;
    if (bypass_count !== 4'd9) begin bad++; $display("FAIL prio_count got=%0d exp=9", bypass_count); end
  endtask

  task automatic test_disabled_read();
    idle();
    drive_write(2, 3'd2, 32'h0000_0055);
    address_out[0*L +: L] = 3'd2;
    step();
    idle();
    step();
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL dis_valid got=%h exp=00", out_valid); end
    total++;
    if (out[0*SZ +: SZ] !== 32'h0000_0033) begin bad++; $display("FAIL dis_hold got=%h exp=00000033", out[0*SZ +: SZ]); end
    total++;
    if (bypass_count !== 4'd9) begin bad++; $display("FAIL dis_count got=%0d exp=9", bypass_count); end
  endtask

  task automatic test_back_to_back();
    logic [SZ-1:0] d [3];
    logic [CW-1:0] exp_cnt [3];
    d[0] = 32'hA0A0_0001; d[1] = 32'hB0B0_0002; d[2] = 32'hC0C0_0003;
    exp_cnt[0] = 4'd8; exp_cnt[1] = 4'd15; exp_cnt[2] = 4'd15;
    // Clear with an empty S1, then three back-to-back cycles of 8-port hits.
    idle();
    clear_count = 1'b1;
    step();
    idle();
    total++;
    if (bypass_count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", bypass_count); end
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 3) begin
        drive_write(0, 3'd1, d[c]);
        for (int k = 0; k < 8; k++) drive_read(k, 3'd1);
      end
      step();
      if (c > 0) begin
        total++;
        if (out[5*SZ +: SZ] !== d[c-1]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", c, out[5*SZ +: SZ], d[c-1]); end
        total++;
        if (out_valid !== 8'hFF) begin bad++; $display("FAIL b2b_valid%0d got=%h exp=ff", c, out_valid); end
        total++;
        if (bypass_count !== exp_cnt[c-1]) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=%0d", c, bypass_count, exp_cnt[c-1]); end
      end
    end
    // The hit sits in S1 while clear_count is asserted, so its increment is discarded.
    idle();
    drive_write(3, 3'd6, 32'h0000_0066);
    drive_read(2, 3'd6);
    step();
    idle();
    clear_count = 1'b1;
    step();
    idle();
    total++;
    if (bypass_count !== 4'd0) begin bad++; $display("FAIL clr_hit_count got=%0d exp=0", bypass_count); end
    total++;
    if (out[2*SZ +: SZ] !== 32'h0000_0066) begin bad++; $display("FAIL clr_hit_data got=%h exp=00000066", out[2*SZ +: SZ]); end
  endtask

  task automatic test_mid_reset();
    idle();
    drive_write(0, 3'd3, 32'h0000_0077);
    drive_read(1, 3'd3);
    step();
    idle();
    drive_read(6, 3'd2);
    rst_n = 1'b0;
    step();
    total++;
    if (out !== '0) begin bad++; $display("FAIL mrst_out got=%h exp=0", out); end
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL mrst_valid got=%h exp=00", out_valid); end
    total++;
    if (bypass_count !== 4'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", bypass_count); end
    rst_n = 1'b1;
    idle();
    step();
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL mrst_dropped got=%h exp=00", out_valid); end
    step();
    total++;
    if (out_valid !== 8'h00) begin bad++; $display("FAIL mrst_dropped2 got=%h exp=00", out_valid); end
    // The first request after reset comes out 2 cycles later.
    drive_read(7, 3'd3);
    step();
    idle();
    step();
    total++;
    if (out_valid !== 8'h80) begin bad++; $display("FAIL post_rst_valid got=%h exp=80", out_valid); end
    total++;
    if (out[7*SZ +: SZ] !== 32'h0000_0077) begin bad++; $display("FAIL post_rst_data got=%h exp=00000077", out[7*SZ +: SZ]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_plain_read();
    test_hazard();
    test_priority();
    test_disabled_read();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
